// File: rtl/counter_pkg.sv
// ============================================================================
// counter_pkg : constants shared by the up counter and the down-counter timer
// Rev 1.0
// ============================================================================
`default_nettype none

package counter_pkg;

   localparam int DEFAULT_CNT_WIDTH = 4;

endpackage : counter_pkg

`default_nettype wire

// File: rtl/down_counter_timer.sv
// ============================================================================
// down_counter_timer : loadable down-counter, one-cycle terminal-count pulse,
//                      optional auto-reload for periodic ticks
// Rev 1.0
// ============================================================================
`default_nettype none

module down_counter_timer
   import counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_CNT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             busy
);

   localparam logic [WIDTH-1:0] c_ZERO = '0;
   localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);

   logic [WIDTH-1:0] r_reload;
   logic             w_step;
   logic             w_terminal;

   assign w_step     = en && busy;
   assign w_terminal = (count == c_ONE);

   // count == 1 is handled explicitly, so the decrement can never wrap
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count    <= c_ZERO;
         r_reload <= c_ZERO;
         tc       <= 1'b0;
         busy     <= 1'b0;
      end else if (load) begin
         count    <= load_val;
         r_reload <= load_val;
         busy     <= (load_val != c_ZERO);
         tc       <= 1'b0;
      end else if (w_step) begin
         if (w_terminal) begin
            tc <= 1'b1;
            if (auto_reload) begin
               count <= r_reload;
            end else begin
               count <= c_ZERO;
               busy  <= 1'b0;
            end
         end else begin
            count <= count - c_ONE;
            tc    <= 1'b0;
         end
      end else begin
         tc <= 1'b0;
      end
   end

endmodule : down_counter_timer

`default_nettype wire

// File: tb/tb_down_counter_timer.sv
// ============================================================================
// tb_down_counter_timer : directed self-checking bench with a behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_down_counter_timer;

   localparam int WIDTH = 4;

   logic             clk;
   logic             rst;
   logic             en;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             auto_reload;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             busy;

   int n_checks = 0;
   int n_pass   = 0;

   down_counter_timer #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .load       (load),
      .load_val   (load_val),
      .auto_reload(auto_reload),
      .count      (count),
      .tc         (tc),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: "remaining" enabled edges until the next terminal event, plus the period
   int m_remaining = 0;
   int m_period    = 0;
   bit m_tc        = 0;
   bit m_running   = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_remaining = 0;
         m_period    = 0;
         m_tc        = 0;
         m_running   = 0;
      end else if (load) begin
         m_period    = int'(load_val);
         m_remaining = m_period;
         m_running   = (m_period > 0);
         m_tc        = 0;
      end else if (en && m_running) begin
         m_remaining = m_remaining - 1;
         m_tc        = (m_remaining == 0);
         if (m_tc && auto_reload) m_remaining = m_period;
         if (m_tc && !auto_reload) m_running = 0;
      end else begin
         m_tc = 0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         check("model_count", 32'(count), 32'(m_remaining));
         check("model_tc",    32'(tc),    32'(m_tc));
         check("model_busy",  32'(busy),  32'(m_running));
      end
   end

   // Pulse load for one edge; returns at the negedge after the load edge
   task automatic do_load(input int v);
      load     = 1'b1;
      load_val = WIDTH'(v);
      @(negedge clk);
      load     = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b1; en = 1'b0; load = 1'b0; load_val = '0; auto_reload = 1'b0;
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      check("reset_count", 32'(count), 0);
      check("reset_busy",  32'(busy),  0);
      check("reset_tc",    32'(tc),    0);
      @(negedge clk);
      rst = 1'b1;

      // One-shot from 5
      en = 1'b1; auto_reload = 1'b0;
      do_load(5);
      for (int i = 0; i <= 5; i++) begin
         #2;
         check("oneshot_count", 32'(count), 32'(5 - i));
         check("oneshot_tc",    32'(tc),    32'(i == 5));
         check("oneshot_busy",  32'(busy),  32'(i != 5));
         @(negedge clk);
      end
      for (int i = 0; i < 10; i++) begin
         #2;
         check("idle_hold_count", 32'(count), 0);
         @(negedge clk);
      end

      // Periodic, period 3
      auto_reload = 1'b1;
      do_load(3);
      for (int i = 0; i < 10; i++) begin
         #2;
         check("periodic_count", 32'(count), 32'(3 - (i % 3)));
         check("periodic_tc",    32'(tc),    32'((i % 3 == 0) && (i > 0)));
         check("periodic_busy",  32'(busy),  1);
         @(negedge clk);
      end

      // Pause at 2, then reload-over-terminal with 9
      auto_reload = 1'b0;
      do_load(4);
      repeat (2) @(negedge clk);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #2;
         check("pause_count", 32'(count), 2);
         check("pause_tc",    32'(tc),    0);
      end
      en = 1'b1;
      @(negedge clk);
      #2;
      check("pre_load_count", 32'(count), 1);
      do_load(9);
      #2;
      check("priority_count", 32'(count), 9);
      check("priority_tc",    32'(tc),    0);
      @(negedge clk);

      // Load of zero
      do_load(0);
      for (int i = 0; i < 5; i++) begin
         #2;
         check("zero_busy", 32'(busy), 0);
         check("zero_tc",   32'(tc),   0);
         @(negedge clk);
      end

      // Full scale 15
      do_load(15);
      n = 1;
      while (tc !== 1'b1 && n < 20) begin
         @(negedge clk);
         if (tc !== 1'b1) n++;
      end
      check("fullscale_edges", 32'(n), 15);
      check("fullscale_count", 32'(count), 0);
      @(negedge clk);
      #2;
      check("fullscale_no_underflow", 32'(count), 0);
      @(negedge clk);

      // Reload 1, periodic
      auto_reload = 1'b1;
      do_load(1);
      for (int i = 0; i < 6; i++) begin
         #2;
         check("reload1_count", 32'(count), 1);
         check("reload1_tc",    32'(tc),    32'(i > 0));
         @(negedge clk);
      end

      // Async reset mid-count
      auto_reload = 1'b0;
      do_load(7);
      repeat (3) @(negedge clk);
      #2;
      check("pre_reset_count", 32'(count), 4);
      rst = 1'b0;
      #1;
      check("async_count", 32'(count), 0);
      check("async_busy",  32'(busy),  0);
      check("async_tc",    32'(tc),    0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #2;
         check("post_reset_count", 32'(count), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_down_counter_timer

`default_nettype wire

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Loadable down-counter and timer. It is the decrementing counterpart of the team's free-running 4-bit up counter.
- It counts a programmed value down to zero and raises a one-cycle terminal-count pulse when it gets there.
- Optional auto-reload turns it into a periodic tick generator.
- Used as a delay/timeout source by control FSMs elsewhere in the design.

Parameters:
- WIDTH, 4: counter and load-value width in bits. Legal range is 2 to 32.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-low reset.
- en, input, 1: count enable. Decrement happens only when en is high.
- load, input, 1: synchronous load strobe.
- load_val, input, WIDTH: start value captured when load is high.
- auto_reload, input, 1: sampled at terminal count. 1 = periodic mode, 0 = one-shot.
- count, output, WIDTH: current counter value (registered).
- tc, output, 1: terminal-count pulse, one cycle wide (registered).
- busy, output, 1: high while a count is in progress (registered).

Behaviour:
- Reset (rst low, asynchronous; any time, including mid-count):
  - count = 0, tc = 0, busy = 0.
  - Internal reload register = 0.
  - Outputs hold these values until the first rising clk edge after rst goes high.
- All state updates happen on the rising clk edge. count, tc and busy come directly from flops; there is no combinational path from inputs to outputs.
- Priority per edge: load > en > hold.
- Load (load = 1):
  - count <= load_val and reload register <= load_val.
  - busy <= (load_val != 0). tc <= 0.
  - en is ignored that cycle.
  - Load of 0: count = 0, busy = 0, and no tc is ever produced.
- Decrement (load = 0, en = 1, busy = 1, count > 1): count <= count - 1; tc <= 0.
- Terminal (load = 0, en = 1, busy = 1, count == 1):
  - tc <= 1 on this edge, so it is visible in the same cycle count shows its new value.
  - If auto_reload = 1: count <= reload register and busy stays 1. The period is therefore exactly N enabled cycles for a load of N.
  - If auto_reload = 0: count <= 0, busy <= 0.
- Idle (busy = 0, count == 0): en has no effect. The count holds at 0; there is no wrap to all-ones.
- Pause (en = 0): count and busy hold; tc <= 0. A tc is never stretched beyond one cycle.
- Arithmetic: an unsigned WIDTH-bit decrement that can never underflow, because the count == 1 case is special-cased.
  - Full scale: load_val = 2^WIDTH - 1 is legal and takes 2^WIDTH - 1 enabled cycles to reach tc.
- Reload value 1 with auto_reload = 1: tc is high on every enabled cycle and count stays 1.
- Changing auto_reload mid-count takes effect only at the next terminal event.
- Load while busy restarts the count immediately. It also overwrites the reload register. A tc that would have occurred that edge is suppressed.
- Latency: load to the first decrement is 1 cycle. The first tc edge is N enabled edges after the load edge.

Decomposition:
- Shared package (counter_pkg): DEFAULT_CNT_WIDTH = 4, shared with the up counter.
- Single flat module; no sub-module. The datapath (counter plus reload register) and the busy/tc control are small enough to stay inline.

Test Plan:
- Reset/one-shot:
  - Stimulus: hold rst low 2 cycles, release; load_val = 5 with load pulsed; en = 1; auto_reload = 0.
  - Required: count shows 5, 4, 3, 2, 1, 0 on successive edges. tc is high only in the cycle count becomes 0. busy falls in that same cycle. count then holds 0 for 10 more cycles with en = 1.
- Periodic:
  - Stimulus: load_val = 3, auto_reload = 1, en = 1 continuously.
  - Required: count sequence 3, 2, 1, 3, 2, 1, 3... tc asserts every 3rd cycle, exactly 1 cycle wide. busy stays 1 throughout.
- Pause and priority:
  - Stimulus: load 4; deassert en for 3 cycles when count = 2.
  - Required: count holds at 2 and tc stays 0 during the pause.
  - Then, with count = 1 and en = 1, assert load with load_val = 9. Required: count = 9, no tc.
- Boundaries, each a separate run:
  - load_val = 0: busy stays 0, tc never asserts.
  - load_val = 15 with WIDTH = 4: tc occurs after exactly 15 enabled cycles, with no underflow past 0.
  - load_val = 1 with auto_reload = 1: tc asserts every cycle.
- Async reset mid-count:
  - Stimulus: load 7, count down to 4, drive rst low between clk edges.
  - Required: count = 0, busy = 0, tc = 0 immediately, without waiting for a clk edge. After release with en = 1 and no load, count stays 0.
